// File: rtl/dircc_types_pkg.sv
// Shared types for the DIRCC handler scheduler: FSM states, handler selects
// and the rts_ready flag position that requests a compute step.
package dircc_types_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StRecv    = 2'd1,
        StSend    = 2'd2,
        StCompute = 2'd3
    } sched_state_t;

    typedef enum logic [1:0] {
        SelNone    = 2'd0,
        SelRecv    = 2'd1,
        SelSend    = 2'd2,
        SelCompute = 2'd3
    } handler_sel_t;

    localparam int unsigned DIRCC_RTS_FLAGS_COMPUTE = 31;

endpackage

// File: rtl/dircc_handler_scheduler_if.sv
// Handshake bundle between the handler scheduler (master) and the receive
// queue, packet sender and status register (slave).
interface dircc_handler_scheduler_if #(
    parameter int unsigned LAMPORT_WIDTH = 32
);
    import dircc_types_pkg::*;

    logic [31:0]              rts_ready;
    logic                     recv_valid;
    logic [LAMPORT_WIDTH-1:0] recv_lamport;
    logic                     recv_ack;
    logic                     send_valid;
    logic                     send_ready;
    logic [4:0]               send_port;
    logic [LAMPORT_WIDTH-1:0] send_lamport;
    handler_sel_t             state_sel;
    logic                     state_commit;
    logic [LAMPORT_WIDTH-1:0] lamport;

    modport master (
        input  rts_ready, recv_valid, recv_lamport, send_ready,
        output recv_ack, send_valid, send_port, send_lamport, state_sel, state_commit, lamport
    );

    modport slave (
        output rts_ready, recv_valid, recv_lamport, send_ready,
        input  recv_ack, send_valid, send_port, send_lamport, state_sel, state_commit, lamport
    );

endinterface

// File: rtl/dircc_rr_port_select.sv
// Round-robin port pick: lowest set index at or above rr_ptr, otherwise the
// lowest set index overall.
module dircc_rr_port_select #(
    parameter int unsigned NUM_PORTS = 31
) (
    input  logic [NUM_PORTS-1:0] mask,
    input  logic [4:0]           rr_ptr,
    output logic [4:0]           index,
    output logic                 found
);

    logic [4:0] hi_idx;
    logic [4:0] lo_idx;
    logic       hi_found;

    // Descending scan so the last hit is the lowest index in each class.
    always_comb begin
        hi_idx   = '0;
        lo_idx   = '0;
        hi_found = 1'b0;
        for (int i = int'(NUM_PORTS) - 1; i >= 0; i--) begin
            if (mask[i]) begin
                lo_idx = 5'(i);
                if (5'(i) >= rr_ptr) begin
                    hi_idx   = 5'(i);
                    hi_found = 1'b1;
                end
            end
        end
    end

    assign found = |mask;
    assign index = hi_found ? hi_idx : lo_idx;

endmodule

// File: rtl/dircc_handler_scheduler.sv
// Arbitrates receive, send and compute handlers one at a time, maintains the
// Lamport clock and tells the status register which handler's state to commit.
module dircc_handler_scheduler
    import dircc_types_pkg::*;
#(
    parameter int unsigned NUM_PORTS     = 31,
    parameter int unsigned STARVE_LIMIT  = 4,
    parameter int unsigned LAMPORT_WIDTH = 32
) (
    input logic                       clk,
    input logic                       reset,
    dircc_handler_scheduler_if.master bus
);

    localparam int unsigned CntW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_LIMIT);
    localparam logic [LAMPORT_WIDTH-1:0] LampOne = LAMPORT_WIDTH'(1);

    sched_state_t             state_q;
    logic [LAMPORT_WIDTH-1:0] lamport_q;
    logic [LAMPORT_WIDTH-1:0] send_lamport_q;
    logic [4:0]               send_port_q;
    logic [4:0]               rr_ptr_q;
    logic [CntW-1:0]          starve_cnt_q;
    logic                     recv_ack_q;
    logic                     send_valid_q;

    logic [NUM_PORTS-1:0]     port_mask;
    logic [4:0]               pick_idx;
    logic                     send_elig;
    logic                     starved;
    logic [LAMPORT_WIDTH-1:0] recv_max;

    assign port_mask = bus.rts_ready[NUM_PORTS-1:0];

    dircc_rr_port_select #(
        .NUM_PORTS (NUM_PORTS)
    ) u_rr_port_select (
        .mask   (port_mask),
        .rr_ptr (rr_ptr_q),
        .index  (pick_idx),
        .found  (send_elig)
    );

    assign starved  = send_elig && (starve_cnt_q == StarveMax);
    assign recv_max = (bus.recv_lamport > lamport_q) ? bus.recv_lamport : lamport_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= StIdle;
            lamport_q      <= '0;
            send_lamport_q <= '0;
            send_port_q    <= '0;
            rr_ptr_q       <= '0;
            starve_cnt_q   <= '0;
            recv_ack_q     <= 1'b0;
            send_valid_q   <= 1'b0;
        end else begin
            recv_ack_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.recv_valid && !starved) begin
                        state_q    <= StRecv;
                        recv_ack_q <= 1'b1;
                        if (send_elig && (starve_cnt_q != StarveMax)) begin
                            starve_cnt_q <= starve_cnt_q + CntW'(1);
                        end
                    end else if (send_elig) begin
                        state_q        <= StSend;
                        send_valid_q   <= 1'b1;
                        send_port_q    <= pick_idx;
                        send_lamport_q <= lamport_q + LampOne;
                        starve_cnt_q   <= '0;
                    end else if (bus.rts_ready[DIRCC_RTS_FLAGS_COMPUTE]) begin
                        state_q <= StCompute;
                    end
                end
                StRecv: begin
                    lamport_q <= recv_max + LampOne;
                    state_q   <= StIdle;
                end
                StSend: begin
                    // Payload is frozen until the sender takes it, whatever rts_ready does.
                    if (bus.send_ready) begin
                        lamport_q    <= send_lamport_q;
                        rr_ptr_q     <= (send_port_q == 5'(NUM_PORTS - 1)) ? '0
                                                                          : send_port_q + 5'd1;
                        send_valid_q <= 1'b0;
                        state_q      <= StIdle;
                    end
                end
                StCompute: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    always_comb begin
        bus.state_sel    = SelNone;
        bus.state_commit = 1'b0;
        unique case (state_q)
            StRecv: begin
                bus.state_sel    = SelRecv;
                bus.state_commit = 1'b1;
            end
            StSend: begin
                if (send_valid_q && bus.send_ready) begin
                    bus.state_sel    = SelSend;
                    bus.state_commit = 1'b1;
                end
            end
            StCompute: begin
                bus.state_sel    = SelCompute;
                bus.state_commit = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign bus.recv_ack     = recv_ack_q;
    assign bus.send_valid   = send_valid_q;
    assign bus.send_port    = send_port_q;
    assign bus.send_lamport = send_lamport_q;
    assign bus.lamport      = lamport_q;

endmodule

// File: tb/tb_dircc_handler_scheduler.sv
// Scoreboard bench: every expected commit is queued when stimulus is driven
// and checked by a monitor when the scheduler pulses state_commit.
module tb_dircc_handler_scheduler;

    typedef struct {
        logic [1:0]  sel;
        logic [31:0] lam_after;
        logic [4:0]  port;
        logic [31:0] slam;
    } exp_t;

    logic  clk = 1'b0;
    logic  reset = 1'b1;
    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    exp_t  exp_q[$];
    logic [31:0] model_lam = '0;

    dircc_handler_scheduler_if #(.LAMPORT_WIDTH(32)) bus ();

    dircc_handler_scheduler #(
        .NUM_PORTS     (31),
        .STARVE_LIMIT  (4),
        .LAMPORT_WIDTH (32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Commit monitor
    initial begin
        exp_t cur;
        int   last = -10;
        forever begin
            @(negedge clk);
            if (bus.state_commit) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_commit", 64'(bus.state_sel), 64'(0));
                end else begin
                    cur = exp_q.pop_front();
                    check("commit_sel", 64'(bus.state_sel), 64'(cur.sel));
                    check("commit_gap", 64'((cyc - last) >= 2), 64'(1));
                    last = cyc;
                    if (cur.sel == 2'd1) check("recv_ack", 64'(bus.recv_ack), 64'(1));
                    if (cur.sel == 2'd2) begin
                        check("send_port", 64'(bus.send_port), 64'(cur.port));
                        check("send_lamport", 64'(bus.send_lamport), 64'(cur.slam));
                    end
                    @(posedge clk);
                    #1;
                    check("lamport_after", 64'(bus.lamport), 64'(cur.lam_after));
                end
            end else begin
                check("idle_sel", 64'(bus.state_sel), 64'(0));
            end
        end
    end

    task automatic do_recv(input logic [31:0] stamp);
        exp_t e;
        int   n = 0;
        e.sel       = 2'd1;
        e.lam_after = ((stamp > model_lam) ? stamp : model_lam) + 32'd1;
        e.port      = '0;
        e.slam      = '0;
        model_lam   = e.lam_after;
        exp_q.push_back(e);
        bus.recv_valid   = 1'b1;
        bus.recv_lamport = stamp;
        do begin @(negedge clk); n++; end while (!bus.recv_ack && n < 50);
        check("recv_ack_seen", 64'(bus.recv_ack), 64'(1));
        @(posedge clk);
        #1 bus.recv_valid = 1'b0;
    endtask

    task automatic push_send(input logic [4:0] port);
        exp_t e;
        model_lam   = model_lam + 32'd1;
        e.sel       = 2'd2;
        e.port      = port;
        e.slam      = model_lam;
        e.lam_after = model_lam;
        exp_q.push_back(e);
    endtask

    task automatic do_send(input logic [4:0] port, input int hold);
        int n = 0;
        push_send(port);
        do begin @(negedge clk); n++; end while (!bus.send_valid && n < 50);
        check("send_valid_up", 64'(bus.send_valid), 64'(1));
        bus.rts_ready = '0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("stall_valid", 64'(bus.send_valid), 64'(1));
            check("stall_port", 64'(bus.send_port), 64'(port));
            check("stall_slam", 64'(bus.send_lamport), 64'(model_lam));
            check("stall_commit", 64'(bus.state_commit), 64'(0));
        end
        @(posedge clk);
        #1 bus.send_ready = 1'b1;
        @(posedge clk);
        #1 bus.send_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   n;
        bus.rts_ready    = '0;
        bus.recv_valid   = 1'b0;
        bus.recv_lamport = '0;
        bus.send_ready   = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_lamport", 64'(bus.lamport), 64'(0));
        check("rst_send_valid", 64'(bus.send_valid), 64'(0));
        check("rst_recv_ack", 64'(bus.recv_ack), 64'(0));
        check("rst_commit", 64'(bus.state_commit), 64'(0));
        check("rst_send_port", 64'(bus.send_port), 64'(0));
        check("rst_send_lamport", 64'(bus.send_lamport), 64'(0));
        @(posedge clk);
        #1;

        // Build lamport up to 3, then a receive stamped 10 lands at 11
        for (int i = 0; i < 3; i++) do_recv(32'd0);
        do_recv(32'd10);

        // Round robin over ports 0 and 2
        bus.rts_ready = 32'h0000_0005;
        do_send(5'd0, 0);
        bus.rts_ready = 32'h0000_0005;
        do_send(5'd2, 0);
        bus.rts_ready = 32'h0000_0005;
        do_send(5'd0, 0);

        // Starvation: four receives, then port 3, then the fifth receive
        for (int i = 0; i < 4; i++) begin
            e.sel = 2'd1; e.port = '0; e.slam = '0;
            model_lam = ((32'd100 > model_lam) ? 32'd100 : model_lam) + 32'd1;
            e.lam_after = model_lam;
            exp_q.push_back(e);
        end
        push_send(5'd3);
        e.sel = 2'd1; e.port = '0; e.slam = '0;
        model_lam = ((32'd100 > model_lam) ? 32'd100 : model_lam) + 32'd1;
        e.lam_after = model_lam;
        exp_q.push_back(e);
        bus.recv_lamport = 32'd100;
        bus.rts_ready    = 32'h0000_0008;
        bus.recv_valid   = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.send_valid && n < 60);
        check("starve_send_up", 64'(bus.send_valid), 64'(1));
        bus.rts_ready = '0;
        @(posedge clk);
        #1 bus.send_ready = 1'b1;
        @(posedge clk);
        #1 bus.send_ready = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.recv_ack && n < 50);
        check("fifth_recv_seen", 64'(bus.recv_ack), 64'(1));
        @(posedge clk);
        #1 bus.recv_valid = 1'b0;

        // Compute only: a commit every other cycle, lamport unchanged
        for (int i = 0; i < 5; i++) begin
            e.sel = 2'd3; e.port = '0; e.slam = '0; e.lam_after = model_lam;
            exp_q.push_back(e);
        end
        bus.rts_ready = 32'h8000_0000;
        repeat (10) @(posedge clk);
        #1 bus.rts_ready = '0;
        repeat (3) @(negedge clk);
        check("compute_drained", 64'(exp_q.size()), 64'(0));
        @(posedge clk);
        #1;

        // Lamport wrap, then a long send stall with rts_ready dropped
        do_recv(32'hFFFF_FFFF);
        check("wrap_zero", 64'(bus.lamport), 64'(0));
        bus.rts_ready = 32'h0000_0020;
        do_send(5'd5, 20);

        // Reset in the middle of a send
        bus.rts_ready = 32'h0000_0080;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.send_valid && n < 50);
        check("pre_reset_valid", 64'(bus.send_valid), 64'(1));
        #2 reset = 1'b1;
        #1;
        check("reset_send_valid", 64'(bus.send_valid), 64'(0));
        check("reset_commit", 64'(bus.state_commit), 64'(0));
        check("reset_lamport", 64'(bus.lamport), 64'(0));
        bus.rts_ready = '0;
        model_lam = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // rr_ptr must be back at 0: ports 0 and 8 pick 0
        do_recv(32'd5);
        bus.rts_ready = 32'h0000_0101;
        do_send(5'd0, 0);
        bus.rts_ready = '0;

        repeat (5) @(negedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dircc_handler_scheduler.md
DIRCC_HANDLER_SCHEDULER -- requirements
Module: dircc_handler_scheduler

Interface
REQ-001 Parameter NUM_PORTS, default 31, SHALL set the number of send ports, mapped to rts_ready[NUM_PORTS-1:0].
REQ-002 Parameter STARVE_LIMIT, default 4, SHALL set the maximum consecutive receive grants while a send is eligible.
REQ-003 Parameter LAMPORT_WIDTH, default 32, SHALL set the Lamport counter width.
REQ-004 clk  in  1  sole clock; all state SHALL be on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 rts_ready  in  32  per-port ready-to-send; bit 31 = compute flag (DIRCC_RTS_FLAGS_COMPUTE).
REQ-007 recv_valid  in  1  received packet awaiting its handler; held until recv_ack.
REQ-008 recv_lamport  in  LAMPORT_WIDTH  Lamport stamp of that packet, stable while recv_valid.
REQ-009 recv_ack  out  1  one-cycle acceptance of the pending receive.
REQ-010 send_valid  out  1  send request; held until send_ready.
REQ-011 send_ready  in  1  packet sender accepts the request.
REQ-012 send_port  out  5  selected port index, stable while send_valid.
REQ-013 send_lamport  out  LAMPORT_WIDTH  stamp for the outgoing packet, stable while send_valid.
REQ-014 state_sel  out  2  handler whose write_state is committed: 0 none, 1 receive, 2 send, 3 compute.
REQ-015 state_commit  out  1  one-cycle pulse; status register SHALL load the state_sel handler's write_state.
REQ-016 lamport  out  LAMPORT_WIDTH  current Lamport clock.

Function
REQ-017 FSM states IDLE, RECV, SEND, COMPUTE; each commit SHALL return to IDLE, giving at least one IDLE cycle between grants.
REQ-018 Send is eligible in IDLE when rts_ready[NUM_PORTS-1:0] is non-zero.
REQ-019 IDLE priority: RECV if recv_valid (unless starved); else SEND if eligible; else COMPUTE if rts_ready[31]; else stay IDLE.
REQ-020 Starved: starve_cnt == STARVE_LIMIT with send eligible; SEND SHALL then win over recv_valid.
REQ-021 starve_cnt SHALL increment on entry to RECV while send eligible, saturate at STARVE_LIMIT, and clear on entry to SEND.
REQ-022 RECV lasts one cycle: recv_ack=1, state_sel=1, state_commit=1, and lamport <= max(lamport, recv_lamport)+1.
REQ-023 On IDLE->SEND, send_port and send_lamport=lamport+1 SHALL be latched; send_valid asserts the next cycle.
REQ-024 Port choice: the lowest set port index >= rr_ptr; if none, the lowest set index overall (wrap).
REQ-025 In SEND, on send_valid&&send_ready: lamport <= send_lamport, state_sel=2, state_commit=1, rr_ptr <= (send_port+1) mod NUM_PORTS, then IDLE.
REQ-026 send_valid SHALL NOT deassert or change payload before send_ready, even if rts_ready drops.
REQ-027 COMPUTE lasts one cycle: state_sel=3, state_commit=1; lamport unchanged.
REQ-028 Lamport arithmetic SHALL be unsigned, wrapping modulo 2^LAMPORT_WIDTH; max uses unsigned compare.
REQ-029 recv_valid arriving during SEND or COMPUTE SHALL wait; a receive is never dropped.
REQ-030 state_commit SHALL be 0, and state_sel 0, in every cycle not listed in REQ-022/025/027.

Reset
REQ-031 Reset SHALL force IDLE, lamport=0, rr_ptr=0, starve_cnt=0, send_port=0, send_lamport=0, and all outputs 0.
REQ-032 Reset mid-SEND SHALL drop send_valid immediately and abandon the request without commit.

Structure
REQ-033 The sched_state_t enum, handler_sel_t (2-bit) and DIRCC_RTS_FLAGS_COMPUTE SHALL be placed in dircc_types_pkg.
REQ-034 Round-robin port search SHALL be a combinational sub-module, dircc_rr_port_select (inputs mask, rr_ptr; outputs index, found).

Verification
REQ-035 recv_valid=1, recv_lamport=10, lamport=3 -> recv_ack and state_sel=1 one cycle; lamport=11.
REQ-036 rts_ready=0x0000_0005, rr_ptr=0 -> send_port=0, send_lamport=lamport+1; after send_ready the next send is port 2, then port 0.
REQ-037 recv_valid held high, rts_ready[3]=1, STARVE_LIMIT=4 -> four RECV commits, then SEND port 3 before the fifth receive.
REQ-038 rts_ready=0x8000_0000 only -> COMPUTE commit every other cycle; lamport constant.
REQ-039 recv_lamport=0xFFFF_FFFF -> lamport wraps to 0; send_ready held low 20 cycles with rts_ready cleared -> send_valid and payload stable.
REQ-040 reset asserted while send_valid=1 -> send_valid=0 asynchronously, no state_commit, lamport=0.
